// File: rtl/ttt_pkg.sv
// Shared types and constants for the tic-tac-toe game controller:
// state encodings, cell indices, win-line masks and cursor stepping.
package ttt_pkg;

  localparam int unsigned BOARD_CELLS = 9;
  localparam int unsigned NUM_LINES   = 8;

  // Row-major cell indices, row 0 at the top.
  localparam logic [3:0] CELL_TL = 4'd0;
  localparam logic [3:0] CELL_TC = 4'd1;
  localparam logic [3:0] CELL_TR = 4'd2;
  localparam logic [3:0] CELL_ML = 4'd3;
  localparam logic [3:0] CELL_MC = 4'd4;
  localparam logic [3:0] CELL_MR = 4'd5;
  localparam logic [3:0] CELL_BL = 4'd6;
  localparam logic [3:0] CELL_BC = 4'd7;
  localparam logic [3:0] CELL_BR = 4'd8;

  typedef enum logic [4:0] {
    StIdle  = 5'b00001,
    StTurn  = 5'b00010,
    StCheck = 5'b00100,
    StWin   = 5'b01000,
    StDraw  = 5'b10000
  } state_e;

  typedef enum logic [1:0] {
    DirUp,
    DirDown,
    DirLeft,
    DirRight
  } dir_e;

  // Bits 0-2 rows, 3-5 columns, 6 main diagonal, 7 anti-diagonal.
  localparam logic [8:0] WIN_LINE_MASK [NUM_LINES] = '{
    9'b000_000_111,
    9'b000_111_000,
    9'b111_000_000,
    9'b001_001_001,
    9'b010_010_010,
    9'b100_100_100,
    9'b100_010_001,
    9'b001_010_100
  };

  // Cursor step with wrap inside the current row or column.
  function automatic logic [3:0] cursor_move(input logic [3:0] idx, input dir_e dir);
    logic [3:0] col;
    col = idx % 4'd3;
    cursor_move = idx;
    case (dir)
      DirRight: cursor_move = (col == 4'd2) ? idx - 4'd2 : idx + 4'd1;
      DirLeft:  cursor_move = (col == 4'd0) ? idx + 4'd2 : idx - 4'd1;
      DirUp:    cursor_move = (idx < CELL_ML) ? idx + 4'd6 : idx - 4'd3;
      DirDown:  cursor_move = (idx >= CELL_BL) ? idx - 4'd6 : idx + 4'd3;
      default:  cursor_move = idx;
    endcase
  endfunction

endpackage

// File: rtl/ttt_turn_sequencer_if.sv
// Button/strobe inputs and board/status outputs of the game controller.
interface ttt_turn_sequencer_if #(
  parameter int unsigned TICK_W = 4
);
  logic              btn_up;
  logic              btn_down;
  logic              btn_left;
  logic              btn_right;
  logic              btn_center;
  logic              first_p2;
  logic              tick;
  logic [3:0]        cursor;
  logic [8:0]        board_x;
  logic [8:0]        board_o;
  logic              turn_p2;
  logic [3:0]        moves;
  logic [TICK_W-1:0] time_left;
  logic              st_idle;
  logic              st_turn;
  logic              st_check;
  logic              st_win;
  logic              st_draw;
  logic              winner_p2;
  logic [7:0]        win_lines;
  logic              reject;

  modport master (
    output btn_up, btn_down, btn_left, btn_right, btn_center, first_p2, tick,
    input  cursor, board_x, board_o, turn_p2, moves, time_left,
    input  st_idle, st_turn, st_check, st_win, st_draw, winner_p2, win_lines, reject
  );

  modport slave (
    input  btn_up, btn_down, btn_left, btn_right, btn_center, first_p2, tick,
    output cursor, board_x, board_o, turn_p2, moves, time_left,
    output st_idle, st_turn, st_check, st_win, st_draw, winner_p2, win_lines, reject
  );
endinterface

// File: rtl/ttt_line_detect.sv
// Combinational win-line detector: flags every line fully covered by a mask.
module ttt_line_detect
  import ttt_pkg::*;
(
  input  logic [8:0] i_mask,
  output logic [7:0] o_lines
);

  always_comb begin
    o_lines = '0;
    for (int i = 0; i < int'(NUM_LINES); i++) begin
      o_lines[i] = ((i_mask & WIN_LINE_MASK[i]) == WIN_LINE_MASK[i]);
    end
  end

endmodule

// File: rtl/ttt_turn_sequencer.sv
// Tic-tac-toe game controller: cursor, turn order, placement validation,
// per-turn timer and win/draw detection.
module ttt_turn_sequencer
  import ttt_pkg::*;
#(
  parameter int unsigned CURSOR_HOME = 4,
  parameter int unsigned TURN_TICKS  = 10,
  parameter int unsigned TICK_W      = 4
) (
  input logic                  clk,
  input logic                  rst,
  ttt_turn_sequencer_if.slave  io_game
);

  localparam logic [TICK_W-1:0] TIME_RELOAD = TICK_W'(TURN_TICKS);
  localparam logic [3:0]        HOME        = 4'(CURSOR_HOME);

  state_e            r_state;
  logic [3:0]        r_cursor;
  logic [8:0]        r_board_x;
  logic [8:0]        r_board_o;
  logic              r_turn_p2;
  logic [3:0]        r_moves;
  logic [TICK_W-1:0] r_time_left;
  logic              r_winner_p2;
  logic              r_reject;

  logic [8:0] w_cursor_bit;
  logic       w_cell_free;
  logic [8:0] w_mover_mask;
  logic [7:0] w_lines;

  assign w_cursor_bit = 9'(1) << r_cursor;
  assign w_cell_free  = ~|((r_board_x | r_board_o) & w_cursor_bit);
  // In WIN the mover is still the winner, so one detector serves CHECK and WIN.
  assign w_mover_mask = r_turn_p2 ? r_board_o : r_board_x;

  ttt_line_detect u_line_detect (
    .i_mask  (w_mover_mask),
    .o_lines (w_lines)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StIdle;
      r_cursor    <= HOME;
      r_board_x   <= '0;
      r_board_o   <= '0;
      r_turn_p2   <= 1'b0;
      r_moves     <= '0;
      r_time_left <= TIME_RELOAD;
      r_winner_p2 <= 1'b0;
      r_reject    <= 1'b0;
    end else begin
      r_reject <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (io_game.btn_center) begin
            r_state     <= StTurn;
            r_turn_p2   <= io_game.first_p2;
            r_board_x   <= '0;
            r_board_o   <= '0;
            r_moves     <= '0;
            r_cursor    <= HOME;
            r_time_left <= TIME_RELOAD;
          end
        end
        StTurn: begin
          if (io_game.btn_center) begin
            // Placement or rejection both swallow any tick this cycle.
            if (w_cell_free) begin
              if (r_turn_p2) r_board_o <= r_board_o | w_cursor_bit;
              else           r_board_x <= r_board_x | w_cursor_bit;
              r_moves <= r_moves + 4'd1;
              r_state <= StCheck;
            end else begin
              r_reject <= 1'b1;
            end
          end else begin
            if (io_game.btn_right)     r_cursor <= cursor_move(r_cursor, DirRight);
            else if (io_game.btn_left) r_cursor <= cursor_move(r_cursor, DirLeft);
            else if (io_game.btn_up)   r_cursor <= cursor_move(r_cursor, DirUp);
            else if (io_game.btn_down) r_cursor <= cursor_move(r_cursor, DirDown);

            if (io_game.tick && (TURN_TICKS != 0)) begin
              if (r_time_left == TICK_W'(1)) begin
                r_turn_p2   <= ~r_turn_p2;
                r_time_left <= TIME_RELOAD;
              end else begin
                r_time_left <= r_time_left - TICK_W'(1);
              end
            end
          end
        end
        StCheck: begin
          if (|w_lines) begin
            r_state     <= StWin;
            r_winner_p2 <= r_turn_p2;
          end else if (r_moves == 4'(BOARD_CELLS)) begin
            r_state <= StDraw;
          end else begin
            r_turn_p2   <= ~r_turn_p2;
            r_time_left <= TIME_RELOAD;
            r_state     <= StTurn;
          end
        end
        StWin, StDraw: begin
          if (io_game.btn_center) begin
            r_state     <= StIdle;
            r_board_x   <= '0;
            r_board_o   <= '0;
            r_moves     <= '0;
            r_winner_p2 <= 1'b0;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign io_game.cursor    = r_cursor;
  assign io_game.board_x   = r_board_x;
  assign io_game.board_o   = r_board_o;
  assign io_game.turn_p2   = r_turn_p2;
  assign io_game.moves     = r_moves;
  assign io_game.time_left = r_time_left;
  assign io_game.st_idle   = (r_state == StIdle);
  assign io_game.st_turn   = (r_state == StTurn);
  assign io_game.st_check  = (r_state == StCheck);
  assign io_game.st_win    = (r_state == StWin);
  assign io_game.st_draw   = (r_state == StDraw);
  assign io_game.winner_p2 = r_winner_p2;
  assign io_game.win_lines = (r_state == StWin) ? w_lines : 8'h00;
  assign io_game.reject    = r_reject;

endmodule

// File: tb/tb_ttt_turn_sequencer.sv
// Directed bench for the tic-tac-toe controller with hand-computed expectations.
module tb_ttt_turn_sequencer;

  localparam logic [4:0] B_CENTER = 5'b10000;
  localparam logic [4:0] B_RIGHT  = 5'b01000;
  localparam logic [4:0] B_LEFT   = 5'b00100;
  localparam logic [4:0] B_UP     = 5'b00010;
  localparam logic [4:0] B_DOWN   = 5'b00001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_err    = 0;
  int   tb_cur   = 4;

  ttt_turn_sequencer_if #(.TICK_W(4)) game_if ();

  ttt_turn_sequencer #(
    .CURSOR_HOME (4),
    .TURN_TICKS  (10),
    .TICK_W      (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .io_game (game_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [4:0] b);
    {game_if.btn_center, game_if.btn_right, game_if.btn_left,
     game_if.btn_up, game_if.btn_down} = b;
    cyc();
    {game_if.btn_center, game_if.btn_right, game_if.btn_left,
     game_if.btn_up, game_if.btn_down} = 5'b0;
  endtask

  task automatic tick_n(input int n);
    repeat (n) begin
      game_if.tick = 1'b1;
      cyc();
      game_if.tick = 1'b0;
    end
  endtask

  // Walk the cursor using right/down only, from the bench's own cursor model.
  task automatic goto(input int to);
    int dc;
    int dr;
    dc = (to % 3 - tb_cur % 3 + 3) % 3;
    dr = (to / 3 - tb_cur / 3 + 3) % 3;
    repeat (dc) press(B_RIGHT);
    repeat (dr) press(B_DOWN);
    tb_cur = to;
  endtask

  task automatic place();
    press(B_CENTER);
    cyc();
  endtask

  initial begin
    int draw_seq [9];
    draw_seq = '{0, 4, 2, 1, 7, 6, 3, 5, 8};
    {game_if.btn_center, game_if.btn_right, game_if.btn_left,
     game_if.btn_up, game_if.btn_down} = 5'b0;
    game_if.tick     = 1'b0;
    game_if.first_p2 = 1'b0;

    // Reset values
    cyc();
    cyc();
    check("rst_idle",      game_if.st_idle,   1);
    check("rst_cursor",    game_if.cursor,    4);
    check("rst_board_x",   game_if.board_x,   0);
    check("rst_board_o",   game_if.board_o,   0);
    check("rst_moves",     game_if.moves,     0);
    check("rst_turn",      game_if.turn_p2,   0);
    check("rst_time",      game_if.time_left, 10);
    check("rst_winner",    game_if.winner_p2, 0);
    check("rst_reject",    game_if.reject,    0);
    check("rst_win_lines", game_if.win_lines, 0);
    rst = 1'b0;
    cyc();

    // Start game 1
    press(B_CENTER);
    check("start_turn",   game_if.st_turn,   1);
    check("start_p2",     game_if.turn_p2,   0);
    check("start_cursor", game_if.cursor,    4);
    check("start_bx",     game_if.board_x,   0);
    check("start_bo",     game_if.board_o,   0);
    check("start_time",   game_if.time_left, 10);

    // Cursor wrap and priority
    press(B_RIGHT);          check("cur_r1",  game_if.cursor, 5);
    press(B_RIGHT);          check("cur_r2",  game_if.cursor, 3);
    press(B_DOWN);           check("cur_d1",  game_if.cursor, 6);
    press(B_DOWN);           check("cur_d2",  game_if.cursor, 0);
    press(B_RIGHT | B_UP);   check("cur_ru",  game_if.cursor, 1);
    press(B_LEFT);           check("cur_l",   game_if.cursor, 0);
    press(B_LEFT);           check("cur_lw",  game_if.cursor, 2);
    press(B_UP);             check("cur_uw",  game_if.cursor, 8);
    press(B_LEFT | B_DOWN);  check("cur_ld",  game_if.cursor, 7);
    press(B_UP);             check("cur_u",   game_if.cursor, 4);
    tb_cur = 4;

    // P1 places at 4, then P2 is rejected at 4
    press(B_CENTER);
    check("p1_check",  game_if.st_check, 1);
    check("p1_bx",     game_if.board_x,  9'h010);
    check("p1_moves",  game_if.moves,    1);
    check("p1_turn_a", game_if.turn_p2,  0);
    press(B_RIGHT);
    check("chk_drop",  game_if.cursor,   4);
    check("p1_turn_b", game_if.turn_p2,  1);
    check("p1_back",   game_if.st_turn,  1);
    press(B_CENTER);
    check("rej_pulse", game_if.reject,   1);
    check("rej_bo",    game_if.board_o,  0);
    check("rej_turn",  game_if.turn_p2,  1);
    check("rej_moves", game_if.moves,    1);
    check("rej_state", game_if.st_turn,  1);
    cyc();
    check("rej_clear", game_if.reject,   0);

    // Reset mid-turn takes effect without a clock edge
    tick_n(1);
    check("pre_rst_time", game_if.time_left, 9);
    rst = 1'b1;
    #1;
    check("mid_rst_idle", game_if.st_idle,   1);
    check("mid_rst_bx",   game_if.board_x,   0);
    check("mid_rst_turn", game_if.turn_p2,   0);
    check("mid_rst_time", game_if.time_left, 10);
    check("mid_rst_mv",   game_if.moves,     0);
    cyc();
    rst = 1'b0;
    cyc();

    // Game 2: P1 wins on the top row
    press(B_CENTER);
    tb_cur = 4;
    goto(0); place();
    goto(3); place();
    goto(1); place();
    goto(4); place();
    goto(2);
    press(B_CENTER);
    check("win_lat1", game_if.st_win, 0);
    cyc();
    check("win_state",  game_if.st_win,    1);
    check("win_who",    game_if.winner_p2, 0);
    check("win_lines",  game_if.win_lines, 8'h01);
    check("win_moves",  game_if.moves,     5);
    check("win_bx",     game_if.board_x,   9'h007);
    check("win_bo",     game_if.board_o,   9'h018);
    tick_n(2);
    check("win_frozen", game_if.time_left, 10);
    press(B_CENTER);
    check("rst_game_idle", game_if.st_idle,   1);
    check("rst_game_bx",   game_if.board_x,   0);
    check("rst_game_bo",   game_if.board_o,   0);
    check("rst_game_mv",   game_if.moves,     0);
    check("rst_game_wl",   game_if.win_lines, 0);
    press(B_RIGHT);
    check("idle_drop",     game_if.cursor,    2);

    // Game 3: draw
    press(B_CENTER);
    tb_cur = 4;
    for (int i = 0; i < 9; i++) begin
      goto(draw_seq[i]);
      place();
    end
    check("draw_state", game_if.st_draw,   1);
    check("draw_win",   game_if.st_win,    0);
    check("draw_moves", game_if.moves,     9);
    check("draw_lines", game_if.win_lines, 0);
    check("draw_bx",    game_if.board_x,   9'h18D);
    check("draw_bo",    game_if.board_o,   9'h072);
    press(B_CENTER);
    check("draw_idle",  game_if.st_idle,   1);

    // Game 4: timeout, P2 first
    game_if.first_p2 = 1'b1;
    press(B_CENTER);
    tb_cur = 4;
    check("to_first_p2", game_if.turn_p2,   1);
    tick_n(9);
    check("to_time1",    game_if.time_left, 1);
    check("to_turn_a",   game_if.turn_p2,   1);
    tick_n(1);
    check("to_forfeit",  game_if.turn_p2,   0);
    check("to_reload",   game_if.time_left, 10);
    check("to_moves",    game_if.moves,     0);
    check("to_state",    game_if.st_turn,   1);
    tick_n(9);
    check("to_time1b",   game_if.time_left, 1);
    game_if.tick = 1'b1;
    press(B_CENTER);
    game_if.tick = 1'b0;
    check("tc_check",    game_if.st_check,  1);
    check("tc_bx",       game_if.board_x,   9'h010);
    check("tc_turn",     game_if.turn_p2,   0);
    check("tc_time",     game_if.time_left, 1);
    cyc();
    check("tc_next",     game_if.turn_p2,   1);
    check("tc_reload",   game_if.time_left, 10);
    check("tc_moves",    game_if.moves,     1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/ttt_turn_sequencer.md
Name: ttt_turn_sequencer

Overview:
- Game controller for the 3x3 tic-tac-toe board.
- Owns board occupancy (X = player 1, O = player 2), the selection cursor, turn order, move validation, the per-turn timer and win/draw detection.
- Consumes single-cycle button pulses from the debouncer. Feeds the VGA block renderer with cursor index, board masks and game status.

Parameters:
- CURSOR_HOME, 4, cursor index loaded at reset and at each new game (centre cell).
- TURN_TICKS, 10, tick pulses allowed per turn before the turn is forfeited; 0 disables the timer.
- TICK_W, 4, width of the turn-timer counter; must satisfy TURN_TICKS < 2**TICK_W.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- btn_up  in  1  single-cycle pulse: move cursor up.
- btn_down  in  1  single-cycle pulse: move cursor down.
- btn_left  in  1  single-cycle pulse: move cursor left.
- btn_right  in  1  single-cycle pulse: move cursor right.
- btn_center  in  1  single-cycle pulse: place mark / start game / restart.
- first_p2  in  1  sampled when leaving IDLE; 1 means player 2 moves first.
- tick  in  1  timer enable pulse (e.g. 1 Hz strobe).
- cursor  out  4  selected cell, 0..8, row-major, row 0 at top.
- board_x  out  9  player-1 occupancy mask, bit i = cell i.
- board_o  out  9  player-2 occupancy mask.
- turn_p2  out  1  0 = player 1 to move, 1 = player 2 to move.
- moves  out  4  marks placed this game, 0..9.
- time_left  out  TICK_W  remaining ticks in the current turn.
- st_idle, st_turn, st_check, st_win, st_draw  out  1 each  one-hot state flags.
- winner_p2  out  1  valid in WIN: 0 = player 1 won, 1 = player 2 won.
- win_lines  out  8  completed lines, bits 0-2 rows, 3-5 columns, 6 main diagonal, 7 anti-diagonal.
- reject  out  1  one-cycle pulse: placement attempted on an occupied cell.

Behaviour:
- Reset (asynchronous, rst=1):
  - State IDLE.
  - cursor=CURSOR_HOME; board_x=board_o=0; moves=0; turn_p2=0; time_left=TURN_TICKS.
  - winner_p2=0; reject=0. win_lines is combinational and therefore 0.
- Button priority within one cycle: center > right > left > up > down. At most one action per cycle; all other pulses that cycle are dropped.
- Cursor movement (TURN only; ignored in every other state):
  - Wraps within the row/column.
  - right: col 2 -> col 0.
  - left: col 0 -> col 2.
  - up: row 0 -> row 2, i.e. idx-3 mod 9 within the column.
  - down: row 2 -> row 0.
  - Cursor is never outside 0..8.
- IDLE:
  - btn_center -> TURN.
  - turn_p2 <= first_p2; board cleared; moves=0; cursor=CURSOR_HOME; time_left=TURN_TICKS.
- TURN:
  - btn_center on an empty cell: set the mover's mask bit at cursor, moves+1, -> CHECK.
  - btn_center on an occupied cell: reject=1 for one cycle; state, board and timer unchanged.
  - tick while TURN_TICKS != 0: time_left decrements.
  - tick when time_left == 1: turn forfeited. Toggle turn_p2, reload time_left, no mark placed, moves unchanged.
  - btn_center and the expiring tick in the same cycle: the placement wins and the tick is ignored.
- CHECK (exactly 1 cycle; evaluates the updated mover mask):
  - Mover completes a line: -> WIN, winner_p2 = mover.
  - Else moves==9: -> DRAW.
  - Else toggle turn_p2, reload time_left, -> TURN.
  - A win on the ninth move is WIN, not DRAW.
  - Buttons during CHECK are dropped.
- Latency from btn_center to st_win/st_draw/turn change: 2 cycles.
- WIN / DRAW:
  - Board, moves and win_lines are held.
  - btn_center -> IDLE, clearing board, moves and winner_p2.
  - Timer frozen.
- win_lines reflects the mask of winner_p2 in WIN; it is 0 in all other states. Multiple bits may be set (double line on the final move).
- Any rst assertion mid-game returns immediately to the reset values.

Decomposition:
- Package ttt_pkg holds:
  - state one-hot encodings (IDLE, TURN, CHECK, WIN, DRAW);
  - the 8 win-line 9-bit masks;
  - the cell index constants;
  - the BOARD_CELLS=9 constant.
- One sub-module, ttt_line_detect: combinational 9-bit mask -> 8-bit completed-line vector. It is instantiated once on the mover's updated mask.

Test Plan:
- Reset, then btn_center with first_p2=0 -> st_turn=1, turn_p2=0, cursor=4, board_x=0, board_o=0, time_left=10.
- Cursor wrap: from cursor=4 apply right, right, down, down -> cursor=5, 3, 6, 0. Simultaneous right+up pulse from cursor 0 -> cursor=1 only.
- Occupied rejection:
  - P1 places at 4 -> board_x=0x010, turn_p2=1 two cycles later.
  - P2 center at 4 -> reject pulses for 1 cycle; board_o=0, turn_p2 stays 1, moves=1.
- Win: P1 places cells 0, 1, 2 while P2 places 3, 4 -> st_win=1, winner_p2=0, win_lines=8'h01, moves=5. Then btn_center -> st_idle, boards cleared.
- Draw: X at 0,2,3,7,8 and O at 1,4,5,6 -> after the 9th placement st_draw=1, moves=9, win_lines=0.
- Timeout:
  - 10 ticks with no placement -> turn_p2 toggles, time_left=10, moves unchanged.
  - Tick coincident with btn_center at time_left=1 -> mark placed, no forfeit.
  - rst mid-turn -> reset values on the same edge.
